// File: rtl/readback_serializer.sv
// Readback serializer: fetches status/act/param/inst words and
// streams them MSB-byte-first into the SPI TX FIFO.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   start, mem_sel,      command strobe, memory select (00 status,
//   start_addr,          01 param, 10 act, 11 inst), first address,
//   burst_len            extra words after the first
//   abort                cancel the running transfer
//   status_word          byte returned for a status read
//   busy, done           transfer active, one-cycle completion pulse
//   *_mem_addr/rd_data   memory read ports (fixed read latency)
//   tx_fifo_*            TX FIFO write port with full backpressure

module readback_serializer #(
  parameter int WIDTH_SPI_WORD   = 8,
  parameter int WIDTH_ADDR_ACT   = 11,
  parameter int WIDTH_ACT_MEM    = 8,
  parameter int WIDTH_ADDR_PARAM = 13,
  parameter int WIDTH_PARAM_MEM  = 128,
  parameter int WIDTH_ADDR_INST  = 6,
  parameter int WIDTH_INST_MEM   = 80,
  parameter int MEM_RD_LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [1:0]                  mem_sel,
  input  logic [12:0]                 start_addr,
  input  logic [11:0]                 burst_len,
  input  logic                        abort,
  input  logic [7:0]                  status_word,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
  input  logic [WIDTH_ACT_MEM-1:0]    act_mem_rd_data,
  output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
  input  logic [WIDTH_PARAM_MEM-1:0]  param_mem_rd_data,
  output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
  input  logic [WIDTH_INST_MEM-1:0]   inst_mem_rd_data,
  output logic [WIDTH_SPI_WORD-1:0]   tx_fifo_data,
  output logic                        tx_fifo_wr_req,
  input  logic                        tx_fifo_full
);

  localparam int SW = WIDTH_SPI_WORD;
  localparam int BPW_ACT   = (WIDTH_ACT_MEM + SW - 1) / SW;
  localparam int BPW_PARAM = (WIDTH_PARAM_MEM + SW - 1) / SW;
  localparam int BPW_INST  = (WIDTH_INST_MEM + SW - 1) / SW;
  localparam int BPW_STAT  = (8 + SW - 1) / SW;
  localparam int M1 = (BPW_ACT > BPW_PARAM) ? BPW_ACT : BPW_PARAM;
  localparam int M2 = (M1 > BPW_INST) ? M1 : BPW_INST;
  localparam int MAX_BPW = (M2 > BPW_STAT) ? M2 : BPW_STAT;
  localparam int SR_W = MAX_BPW * SW;

  localparam logic [1:0] SEL_STAT  = 2'b00;
  localparam logic [1:0] SEL_PARAM = 2'b01;
  localparam logic [1:0] SEL_ACT   = 2'b10;
  localparam logic [1:0] SEL_INST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, LOAD, SEND, NEXT
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        sel_q;
  logic [12:0]       addr_q;
  logic [11:0]       words_left;
  logic [2:0]        lat_cnt;
  logic [7:0]        byte_cnt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   load_val;
  logic [7:0]        load_cnt;
  logic              done_q;
  logic              last_acc;

  function automatic logic [12:0] addr_mask(input logic [1:0] s);
    logic [12:0] m;
    m = '0;
    case (s)
      SEL_ACT:   m = 13'((1 << WIDTH_ADDR_ACT) - 1);
      SEL_PARAM: m = 13'((1 << WIDTH_ADDR_PARAM) - 1);
      SEL_INST:  m = 13'((1 << WIDTH_ADDR_INST) - 1);
      default:   m = '0;
    endcase
    return m;
  endfunction

  // Word sits zero-extended in the top bpw bytes of the shift register.
  function automatic logic [SR_W-1:0] left_align(
    input logic [SR_W-1:0] v,
    input int              bpw
  );
    return v << (SR_W - bpw * SW);
  endfunction

  always_comb begin
    load_val = '0;
    load_cnt = '0;
    case (sel_q)
      SEL_ACT: begin
        load_val = left_align(SR_W'(act_mem_rd_data), BPW_ACT);
        load_cnt = 8'(BPW_ACT - 1);
      end
      SEL_PARAM: begin
        load_val = left_align(SR_W'(param_mem_rd_data), BPW_PARAM);
        load_cnt = 8'(BPW_PARAM - 1);
      end
      SEL_INST: begin
        load_val = left_align(SR_W'(inst_mem_rd_data), BPW_INST);
        load_cnt = 8'(BPW_INST - 1);
      end
      default: begin
        load_val = left_align(SR_W'(status_word), BPW_STAT);
        load_cnt = 8'(BPW_STAT - 1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    tx_fifo_wr_req = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (mem_sel == SEL_STAT) ? LOAD : ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (lat_cnt == 3'd0) state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (!tx_fifo_full) begin
          tx_fifo_wr_req = 1'b1;
          if (byte_cnt == 8'd0)
            state_nxt = (words_left != 12'd0) ? NEXT : IDLE;
        end
      end
      NEXT: state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) begin
      state_nxt      = IDLE;
      tx_fifo_wr_req = 1'b0;
    end
  end

  assign last_acc = tx_fifo_wr_req && byte_cnt == 8'd0 &&
                    words_left == 12'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q          <= '0;
      addr_q         <= '0;
      words_left     <= '0;
      lat_cnt        <= '0;
      byte_cnt       <= '0;
      sr             <= '0;
      done_q         <= 1'b0;
      act_mem_addr   <= '0;
      param_mem_addr <= '0;
      inst_mem_addr  <= '0;
    end else begin
      done_q <= last_acc;
      if (state == IDLE) begin
        if (start) begin
          sel_q      <= mem_sel;
          addr_q     <= start_addr & addr_mask(mem_sel);
          words_left <= (mem_sel == SEL_STAT) ? 12'd0 : burst_len;
        end
      end else if (!abort) begin
        case (state)
          ISSUE: begin
            lat_cnt <= 3'(MEM_RD_LATENCY - 1);
            case (sel_q)
              SEL_ACT:
                act_mem_addr <= addr_q[WIDTH_ADDR_ACT-1:0];
              SEL_PARAM:
                param_mem_addr <= addr_q[WIDTH_ADDR_PARAM-1:0];
              SEL_INST:
                inst_mem_addr <= addr_q[WIDTH_ADDR_INST-1:0];
              default: ;
            endcase
          end
          WAIT: begin
            if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
          end
          LOAD: begin
            sr       <= load_val;
            byte_cnt <= load_cnt;
          end
          SEND: begin
            if (tx_fifo_wr_req) begin
              sr <= sr << SW;
              if (byte_cnt != 8'd0) byte_cnt <= byte_cnt - 8'd1;
            end
          end
          NEXT: begin
            addr_q     <= (addr_q + 13'd1) & addr_mask(sel_q);
            words_left <= words_left - 12'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign tx_fifo_data = sr[SR_W-1 -: SW];

endmodule

// File: tb/tb_readback_serializer.sv
// Testbench for readback_serializer: vector table plus hand-written
// backpressure, abort, busy-start and reset sequences.

module tb_readback_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   mem_sel;
  logic [12:0]  start_addr;
  logic [11:0]  burst_len;
  logic         abort;
  logic [7:0]   status_word;
  logic         busy;
  logic         done;
  logic [10:0]  act_mem_addr;
  logic [7:0]   act_mem_rd_data;
  logic [12:0]  param_mem_addr;
  logic [127:0] param_mem_rd_data;
  logic [5:0]   inst_mem_addr;
  logic [79:0]  inst_mem_rd_data;
  logic [7:0]   tx_fifo_data;
  logic         tx_fifo_wr_req;
  logic         tx_fifo_full;

  always #5 clk = ~clk;

  readback_serializer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .mem_sel           (mem_sel),
    .start_addr        (start_addr),
    .burst_len         (burst_len),
    .abort             (abort),
    .status_word       (status_word),
    .busy              (busy),
    .done              (done),
    .act_mem_addr      (act_mem_addr),
    .act_mem_rd_data   (act_mem_rd_data),
    .param_mem_addr    (param_mem_addr),
    .param_mem_rd_data (param_mem_rd_data),
    .inst_mem_addr     (inst_mem_addr),
    .inst_mem_rd_data  (inst_mem_rd_data),
    .tx_fifo_data      (tx_fifo_data),
    .tx_fifo_wr_req    (tx_fifo_wr_req),
    .tx_fifo_full      (tx_fifo_full)
  );

  function automatic logic [7:0] act_word(input logic [10:0] a);
    logic [10:0] t;
    t = a * 11'd7 + 11'd3;
    return (a == 11'h005) ? 8'hA7 : t[7:0];
  endfunction

  function automatic logic [127:0] param_word(input logic [12:0] a);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 16; j++)
      w[127-8*j -: 8] = 8'(int'(a) * 16 + j);
    return w;
  endfunction

  function automatic logic [79:0] inst_word(input logic [5:0] a);
    if (a == 6'h20) return 80'h0123456789ABCDEF0011;
    return {{2'b00, a}, 8'hC3, {8{2'b01, a}}};
  endfunction

  // Two-stage read pipeline: data valid two cycles after the address.
  logic [7:0]   act_p1;
  logic [127:0] param_p1;
  logic [79:0]  inst_p1;
  always @(posedge clk) begin
    act_p1            <= act_word(act_mem_addr);
    act_mem_rd_data   <= act_p1;
    param_p1          <= param_word(param_mem_addr);
    param_mem_rd_data <= param_p1;
    inst_p1           <= inst_word(inst_mem_addr);
    inst_mem_rd_data  <= inst_p1;
  end

  typedef struct {
    logic [1:0]  sel;
    logic [12:0] addr;
    logic [11:0] blen;
    logic [7:0]  stat;
    int          nbytes;
    logic [12:0] last_addr;
  } vec_t;

  vec_t      vecs[8];
  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int last_acc_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_expected(input logic [1:0] sel,
                               input logic [12:0] addr,
                               input logic [11:0] blen,
                               input logic [7:0] stat);
    logic [12:0]  a;
    logic [127:0] w;
    if (sel == 2'b00) begin
      q.push_back(stat);
      return;
    end
    a = addr;
    for (int k = 0; k <= int'(blen); k++) begin
      case (sel)
        2'b10: begin
          a = a & 13'h07FF;
          q.push_back(act_word(a[10:0]));
        end
        2'b01: begin
          w = param_word(a);
          for (int j = 0; j < 16; j++) q.push_back(w[127-8*j -: 8]);
        end
        default: begin
          a = a & 13'h003F;
          w = 128'(inst_word(a[5:0]));
          for (int j = 0; j < 10; j++) q.push_back(w[79-8*j -: 8]);
        end
      endcase
      a = a + 13'd1;
    end
  endtask

  task automatic start_txn(input logic [1:0] sel,
                           input logic [12:0] addr,
                           input logic [11:0] blen,
                           input logic [7:0] stat);
    @(posedge clk);
    #1;
    start       = 1'b1;
    mem_sel     = sel;
    start_addr  = addr;
    burst_len   = blen;
    status_word = stat;
    push_expected(sel, addr, blen, stat);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int d0, input int bound);
    int t;
    t = 0;
    while (done_cnt == d0 && t < bound) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done");
    end
  endtask

  task automatic wait_acc(input int target, input int bound);
    int t;
    t = 0;
    while (acc < target && t < bound) begin
      @(posedge clk);
      t++;
    end
    if (acc < target) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got %0d expected %0d", acc, target);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int a0, d0;
    logic [12:0] pa, pp, pi;
    a0 = acc;
    d0 = done_cnt;
    pa = 13'(act_mem_addr);
    pp = param_mem_addr;
    pi = 13'(inst_mem_addr);
    start_txn(v.sel, v.addr, v.blen, v.stat);
    wait_done(d0, 40000);
    #1;
    check("nbytes", 64'(acc - a0), 64'(v.nbytes));
    check("queue_empty", 64'(q.size()), 0);
    check("done_count", 64'(done_cnt - d0), 1);
    check("done_latency", 64'(done_cyc), 64'(last_acc_cyc + 1));
    check("busy_idle", busy, 0);
    check("addr_act", 64'(act_mem_addr),
          (v.sel == 2'b10) ? 64'(v.last_addr) : 64'(pa));
    check("addr_param", 64'(param_mem_addr),
          (v.sel == 2'b01) ? 64'(v.last_addr) : 64'(pp));
    check("addr_inst", 64'(inst_mem_addr),
          (v.sel == 2'b11) ? 64'(v.last_addr) : 64'(pi));
    q.delete();
  endtask

  initial begin
    int a0, d0;
    vecs[0] = '{2'b10, 13'h005, 12'd0, 8'h00, 1, 13'h005};
    vecs[1] = '{2'b01, 13'h010, 12'd1, 8'h00, 32, 13'h011};
    vecs[2] = '{2'b11, 13'h03F, 12'd1, 8'h00, 20, 13'h000};
    vecs[3] = '{2'b00, 13'h1ABC, 12'd7, 8'h5C, 1, 13'h000};
    vecs[4] = '{2'b10, 13'h7FE, 12'd2, 8'h00, 3, 13'h000};
    vecs[5] = '{2'b01, 13'h1FFF, 12'd1, 8'h00, 32, 13'h000};
    vecs[6] = '{2'b11, 13'h045, 12'd0, 8'h00, 10, 13'h005};
    vecs[7] = '{2'b10, 13'h400, 12'd4095, 8'h00, 4096, 13'h3FF};

    reset_n      = 1'b0;
    start        = 1'b0;
    mem_sel      = 2'b00;
    start_addr   = '0;
    burst_len    = '0;
    abort        = 1'b0;
    status_word  = 8'h00;
    tx_fifo_full = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
          cyc++;
          if (tx_fifo_full === 1'b1)
            check("no_wr_when_full", tx_fifo_wr_req, 0);
          if (tx_fifo_wr_req === 1'b1) begin
            acc++;
            last_acc_cyc = cyc;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_byte: got %0h expected none",
                       tx_fifo_data);
            end else begin
              check("byte", tx_fifo_data, q.pop_front());
            end
          end
          if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_req", tx_fifo_wr_req, 0);
    check("rst_data", tx_fifo_data, 0);
    check("rst_addrs", {act_mem_addr, param_mem_addr, inst_mem_addr}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure on bytes 3..5, four cycles each.
    a0 = acc;
    d0 = done_cnt;
    start_txn(2'b11, 13'h020, 12'd0, 8'h00);
    for (int b = 2; b <= 4; b++) begin
      wait_acc(a0 + b, 200);
      #1;
      tx_fifo_full = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("held_while_full", 64'(acc - a0), 64'(b));
      tx_fifo_full = 1'b0;
    end
    wait_done(d0, 200);
    #1;
    check("bp_nbytes", 64'(acc - a0), 10);
    check("bp_queue_empty", 64'(q.size()), 0);
    check("bp_done_count", 64'(done_cnt - d0), 1);
    q.delete();

    // Abort after five bytes of a four-word param burst.
    a0 = acc;
    d0 = done_cnt;
    start_txn(2'b01, 13'h020, 12'd3, 8'h00);
    wait_acc(a0 + 5, 200);
    #1;
    abort = 1'b1;
    #2;
    check("abort_wr_low", tx_fifo_wr_req, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle", busy, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 0);
    check("abort_nbytes", 64'(acc - a0), 5);
    check("abort_left", 64'(q.size()), 59);
    q.delete();
    run_vec('{2'b01, 13'h020, 12'd0, 8'h00, 16, 13'h020});

    // A second start during an act burst is ignored.
    a0 = acc;
    d0 = done_cnt;
    start_txn(2'b10, 13'h100, 12'd3, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    start      = 1'b1;
    mem_sel    = 2'b01;
    start_addr = 13'h1234;
    burst_len  = 12'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 400);
    #1;
    check("busy_start_nbytes", 64'(acc - a0), 4);
    check("busy_start_queue", 64'(q.size()), 0);
    check("busy_start_act_addr", 64'(act_mem_addr), 64'h103);
    check("busy_start_param_addr", 64'(param_mem_addr), 64'h020);
    q.delete();
    run_vec('{2'b00, 13'h0000, 12'd0, 8'h5C, 1, 13'h000});

    // Reset in the middle of a transfer.
    a0 = acc;
    d0 = done_cnt;
    start_txn(2'b01, 13'h030, 12'd2, 8'h00);
    wait_acc(a0 + 3, 200);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr_req", tx_fifo_wr_req, 0);
    check("midrst_param_addr", 64'(param_mem_addr), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 0);
    q.delete();
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
